lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store initiator between the MIPS pipeline MEM stage and the word-wide data memory. It accepts byte, halfword and word load/store requests and drives the memory's word address, write data and write enable. It performs lane extraction and sign/zero extension on loads, and a read-modify-write sequence for sub-word stores, because the memory only writes whole words. It raises a stall-free valid/ready handshake toward the pipeline and returns one response per request.

## Interface
- ADDR_W, 32, byte-address width; data width fixed at 32.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  input  1  zero-extend load (lbu/lhu).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data.
- resp_exc  output  1  misaligned access flag, valid with resp_valid.
- mem_addr  output  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_wd  output  32  memory write data.
- mem_we  output  1  memory write enable; memory writes at posedge when high.
- mem_rd  input  32  combinational memory read of mem_addr.

## Operation
- Little-endian lanes: byte k = addr[1:0] occupies bits [8k+7:8k]; half lane = addr[1], bits [16h+15:16h].
- States: IDLE, ACCESS, READ, WRITE, RESP.
- IDLE: handshake = req_valid && req_ready. On handshake, latch addr, size, we, unsigned, wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) -> RESP with exc_q=1. This path exists only when the macro in Configuration is defined.
  - Load or word store -> ACCESS.
  - Byte/half store -> READ.
- ACCESS:
  - Load: capture the extended lane of mem_rd into rdata_q.
  - Store: mem_we=1, mem_wd=wdata_q.
  - Next state: RESP.
- READ: capture mem_rd, replace the target lane with wdata_q low byte/half into merge_q -> WRITE.
- WRITE: mem_we=1, mem_wd=merge_q -> RESP.
- RESP: resp_valid=1 -> IDLE.
- rdata_q is cleared to 0 when any store or misaligned request is accepted. resp_rdata=rdata_q.
- mem_addr={addr_q[ADDR_W-1:2],2'b00} in all states. mem_wd=0 whenever mem_we=0.

## Timing
- Handshake in cycle T:
  - Load / word store: ACCESS T+1, resp_valid T+2.
  - Sub-word store: READ T+1, WRITE T+2, resp_valid T+3.
  - Misaligned: resp_valid T+1, no memory write.
- mem_we is high for exactly one cycle per store, never for loads or misaligned requests.
- Throughput: at most one request per 3 cycles (loads/word stores), 4 cycles for sub-word stores. req_ready is low in ACCESS, READ, WRITE and RESP.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_exc=0, mem_we=0, mem_wd=0, mem_addr=0, all latches 0.
- Reset mid-operation: asynchronous return to IDLE. mem_we drops immediately and the pending request is discarded with no response. A READ-phase sub-word store leaves memory unmodified.
- Requests presented while reset is high are not accepted.

## Configuration
- LSU_MISALIGN_EXC_EN defined: misaligned requests are detected and answered with resp_exc=1, resp_rdata=0, and no memory access.
- Undefined: no detection and resp_exc is tied 0. Half accesses use addr[1] only; word accesses ignore addr[1:0].

## Structure
- lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum;
  - the lane-width constants.
- Sub-module lsu_lane_align is purely combinational and provides:
  - load extraction/extension (word, addr[1:0], size, unsigned -> 32-bit result);
  - store merge (old word, wdata, addr[1:0], size -> new word).
- The FSM and registers live in lsu_ctrl.

## Test plan
- sw addr 0x10 data 0x12345678 -> mem_we high at T+1 only, mem_addr 0x10, mem_wd 0x12345678; resp_valid at T+2, resp_exc 0.
- Word 0x10=0x12345678, sb addr 0x11 data 0xAB -> READ T+1, mem_we at T+2 with mem_wd 0x1234AB78, resp T+3; sh addr 0x12 data 0xBEEF -> mem_wd 0xBEEFAB78.
- Word 0x10=0x80FF7F01 loads:
  - lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080;
  - lb 0x11 -> 0x0000007F;
  - lh 0x12 -> 0xFFFF80FF; lhu 0x12 -> 0x000080FF;
  - lw 0x10 -> 0x80FF7F01.
- lw 0x06 / sh 0x03:
  - macro on: resp_exc=1 at T+1, no mem_we.
  - macro off: lw returns word 0x04; sh writes the upper half of word 0x00.
- Assert reset during WRITE of sb -> mem_we falls the same cycle, no resp_valid, req_ready=1, memory word unchanged.
- req_valid held high with three alternating lw/sw -> accepts spaced exactly 3 cycles apart, responses in order, one mem_we per sw.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states, lane widths.
// The misaligned check is only used when LSU_MISALIGN_EXC_EN is defined.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Size 2'b11 behaves as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational little-endian lane logic: load extraction with sign/zero extension
// and sub-word store merge into an existing memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  always_comb begin
    byte_lane = word[{off, 3'b000} +: BYTE_W];
    half_lane = off[1] ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];

    case (size)
      SZ_BYTE: load_data = uns ? {{(WORD_W-BYTE_W){1'b0}}, byte_lane}
                               : {{(WORD_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
      SZ_HALF: load_data = uns ? {{(WORD_W-HALF_W){1'b0}}, half_lane}
                               : {{(WORD_W-HALF_W){half_lane[HALF_W-1]}}, half_lane};
      default: load_data = word;
    endcase

    // Half lanes are selected by off[1] alone, so off[0] is ignored for halves.
    merge_data = word;
    case (size)
      SZ_BYTE: merge_data[{off, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      SZ_HALF: begin
        if (off[1]) merge_data[WORD_W-1:HALF_W] = wdata[HALF_W-1:0];
        else        merge_data[HALF_W-1:0]      = wdata[HALF_W-1:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between MEM stage and a word-wide memory; sub-word stores use
// read-modify-write. Define LSU_MISALIGN_EXC_EN to detect and flag misaligned accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_exc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rd
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              uns_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] merge_data;
  logic              handshake;
  logic              misaligned;
  logic              sub_word;

  assign handshake = req_valid && req_ready;
  assign sub_word  = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

`ifdef LSU_MISALIGN_EXC_EN
  logic exc_q;
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign resp_exc   = exc_q;
`else
  assign misaligned = 1'b0;
  assign resp_exc   = 1'b0;
`endif

  lsu_lane_align u_align (
    .word       (mem_rd),
    .wdata      (wdata_q),
    .off        (addr_q[1:0]),
    .size       (size_q),
    .uns        (uns_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign resp_rdata = rdata_q;

  // mem_we/mem_wd are registered on entry to ACCESS/WRITE; mem_wd also serves as
  // the merged-word register for read-modify-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      mem_wd     <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      mem_wd     <= '0;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            addr_q    <= req_addr;
            size_q    <= req_size;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (misaligned) begin
              rdata_q    <= '0;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
`ifdef LSU_MISALIGN_EXC_EN
              exc_q      <= 1'b1;
`endif
            end else begin
`ifdef LSU_MISALIGN_EXC_EN
              exc_q <= 1'b0;
`endif
              if (req_we) rdata_q <= '0;
              if (req_we && sub_word) begin
                state <= ST_READ;
              end else begin
                state <= ST_ACCESS;
                if (req_we) begin
                  mem_we <= 1'b1;
                  mem_wd <= req_wdata;
                end
              end
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q) rdata_q <= load_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_READ: begin
          mem_we <= 1'b1;
          mem_wd <= merge_data;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed and random requests against a
// transaction-level model with a word memory image; honours LSU_MISALIGN_EXC_EN.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ram_clear;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_exc, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] ram  [0:63];
  logic [31:0] gold [0:63];

  typedef struct { int cyc; logic [31:0] rdata; logic exc; } resp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  int    hs_cyc[$];

  int checks = 0, failures = 0;
  int cyc = 0, busy_until = 0;
  int we_count = 0, we_cyc = 0, resp_cyc = 0, resp_count = 0;
  logic [31:0] last_wd, last_wa, last_rdata;
  logic        last_exc;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  assign mem_rd = ram[mem_addr[7:2]];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
    end else if (mem_we) begin
      ram[mem_addr[7:2]] <= mem_wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      v = (w >> sh) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'(a[1]);
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * int'(a[1]);
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_EXC_EN
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    bit exp_r, exp_w;
    int idx;
    logic [31:0] wa;
    cyc++;
    if (mem_we) begin
      we_count++; we_cyc = cyc; last_wd = mem_wd; last_wa = mem_addr;
    end
    if (resp_valid) begin
      resp_count++; resp_cyc = cyc; last_rdata = resp_rdata; last_exc = resp_exc;
    end
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) gold[i] = 32'h0;
    end
    if (reset) begin
      rq.delete();
      wq.delete();
      busy_until = 0;
    end else begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, cyc >= busy_until});
      exp_r = (rq.size() > 0) && (rq[0].cyc == cyc);
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_r});
      if (exp_r) begin
        chk("resp_rdata", resp_rdata, rq[0].rdata);
        chk("resp_exc", {31'b0, resp_exc}, {31'b0, rq[0].exc});
        void'(rq.pop_front());
      end
      exp_w = (wq.size() > 0) && (wq[0].cyc == cyc);
      chk("mem_we", {31'b0, mem_we}, {31'b0, exp_w});
      if (exp_w) begin
        chk("mem_wd", mem_wd, wq[0].data);
        chk("mem_addr", mem_addr, wq[0].addr);
        gold[wq[0].addr[7:2]] = wq[0].data;
        void'(wq.pop_front());
      end else begin
        chk("mem_wd_idle", mem_wd, 32'h0);
      end
      if (req_valid && cyc >= busy_until) begin
        hs_cyc.push_back(cyc);
        idx = int'(req_addr[7:2]);
        wa = {req_addr[31:2], 2'b00};
        if (misal(req_size, req_addr)) begin
          rq.push_back('{cyc + 1, 32'h0, 1'b1});
          busy_until = cyc + 2;
        end else if (!req_we) begin
          rq.push_back('{cyc + 2, exp_load(gold[idx], req_addr, req_size, req_unsigned), 1'b0});
          busy_until = cyc + 3;
        end else if (req_size == 2'd0 || req_size == 2'd1) begin
          wq.push_back('{cyc + 2, wa, exp_merge(gold[idx], req_wdata, req_addr, req_size)});
          rq.push_back('{cyc + 3, 32'h0, 1'b0});
          busy_until = cyc + 4;
        end else begin
          wq.push_back('{cyc + 1, wa, req_wdata});
          rq.push_back('{cyc + 2, 32'h0, 1'b0});
          busy_until = cyc + 3;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input bit hold);
    int n = 0;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 20);
    if (!req_ready) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || wq.size() != 0) chk("idle_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h0, wc0;
    reset = 1'b1; ram_clear = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_exc", {31'b0, resp_exc}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; ram_clear = 1'b0;
    @(posedge clk); #1;

    // model pinned by hand-computed values
    chk("model_lb", exp_load(32'h80FF7F01, 32'h13, 2'd0, 1'b0), 32'hFFFFFF80);
    chk("model_sb", exp_merge(32'h12345678, 32'hAB, 32'h11, 2'd0), 32'h1234AB78);

    // sw then sub-word stores
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 1'b0); wait_idle();
    chk("sw_wd", last_wd, 32'h12345678);
    chk("sw_addr", last_wa, 32'h10);
    chk("sw_we_lat", we_cyc - hs_cyc[$], 1);
    chk("sw_resp_lat", resp_cyc - hs_cyc[$], 2);
    chk("sw_exc", {31'b0, last_exc}, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hAB, 1'b0); wait_idle();
    chk("sb_wd", last_wd, 32'h1234AB78);
    chk("sb_we_lat", we_cyc - hs_cyc[$], 2);
    chk("sb_resp_lat", resp_cyc - hs_cyc[$], 3);
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hBEEF, 1'b0); wait_idle();
    chk("sh_wd", last_wd, 32'hBEEFAB78);

    // load extension
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 1'b0); wait_idle();
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0); wait_idle();
    chk("lb13", last_rdata, 32'hFFFFFF80);
    chk("lb_resp_lat", resp_cyc - hs_cyc[$], 2);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0); wait_idle();
    chk("lbu13", last_rdata, 32'h00000080);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0); wait_idle();
    chk("lb11", last_rdata, 32'h0000007F);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0); wait_idle();
    chk("lh12", last_rdata, 32'hFFFF80FF);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0); wait_idle();
    chk("lhu12", last_rdata, 32'h000080FF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0); wait_idle();
    chk("lw10", last_rdata, 32'h80FF7F01);

    // misaligned lw 0x06 / sh 0x03
    issue(1'b1, 2'd2, 1'b0, 32'h04, 32'hCAFEF00D, 1'b0); wait_idle();
    wc0 = we_count;
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0); wait_idle();
`ifdef LSU_MISALIGN_EXC_EN
    chk("lw06_exc", {31'b0, last_exc}, 32'h1);
    chk("lw06_rdata", last_rdata, 32'h0);
    chk("lw06_lat", resp_cyc - hs_cyc[$], 1);
    issue(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234, 1'b0); wait_idle();
    chk("sh03_exc", {31'b0, last_exc}, 32'h1);
    chk("sh03_no_we", we_count - wc0, 0);
`else
    chk("lw06_word", last_rdata, 32'hCAFEF00D);
    issue(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234, 1'b0); wait_idle();
    chk("sh03_wd", last_wd, 32'h12340000);
    chk("sh03_addr", last_wa, 32'h0);
    chk("sh03_one_we", we_count - wc0, 1);
`endif

    // reset during WRITE of a sub-word store, requests offered during reset
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b0); wait_idle();
    h0 = resp_count;
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h55, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rstw_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rstw_ready", {31'b0, req_ready}, 32'h1);
    chk("rstw_resp", {31'b0, resp_valid}, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0; reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstw_no_resp", resp_count - h0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0); wait_idle();
    chk("rstw_word", last_rdata, 32'h11223344);

    // back-to-back with req_valid held high
    wc0 = we_count;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h14, 32'h5A5A5A5A, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1);
    req_valid = 1'b0;
    wait_idle();
    chk("b2b_gap1", hs_cyc[$-1] - hs_cyc[$-2], 3);
    chk("b2b_gap2", hs_cyc[$] - hs_cyc[$-1], 3);
    chk("b2b_rdata", last_rdata, 32'h5A5A5A5A);
    chk("b2b_one_we", we_count - wc0, 1);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 64; i++) chk("ram_image", ram[i], gold[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
